// File: rtl/maze_path_generator.sv
// Writer side of the 64x64 maze path bitmap: clear, carve a binary-tree
// maze one cell per clock, then open entrance and exit and pulse done.
module maze_path_generator #(
  parameter int          GRID      = 64,
  parameter logic [15:0] SEED_DFLT = 16'hACE1,
  parameter logic [15:0] LFSR_TAPS = 16'hB400
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [15:0]            seed,
  input  logic [6:0]             maze_width,
  input  logic [6:0]             maze_height,
  output logic                   busy,
  output logic                   done,
  output logic [GRID*GRID-1:0]   path_data
);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    CARVE,
    FINISH
  } state_t;

  state_t                 state_q, state_d;
  logic [GRID*GRID-1:0]   path_q, path_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic [6:0]             x_q, x_d;
  logic [6:0]             y_q, y_d;
  logic [6:0]             x_last_q, x_last_d;
  logic [6:0]             y_last_q, y_last_d;
  logic                   done_q, done_d;

  logic [11:0] cur_idx;
  logic [11:0] east_idx;
  logic [11:0] north_idx;
  logic [11:0] exit_idx;
  logic        can_e;
  logic        can_n;

  // Clamp to 3..64 and return the last odd cell coordinate.
  function automatic logic [6:0] last_of(input logic [6:0] v);
    logic [6:0] c;
    c = (v < 7'd3) ? 7'd3 : ((v > 7'd64) ? 7'd64 : v);
    c = c - 7'd1;
    return {c[6:1], 1'b0} - 7'd1;
  endfunction

  assign cur_idx   = {y_q[5:0], x_q[5:0]};
  assign east_idx  = {y_q[5:0], x_q[5:0] + 6'd1};
  assign north_idx = {y_q[5:0] - 6'd1, x_q[5:0]};
  assign exit_idx  = {y_last_q[5:0], x_last_q[5:0] + 6'd1};
  assign can_e     = x_q < x_last_q;
  assign can_n     = y_q > 7'd1;

  always_comb begin
    state_d  = state_q;
    path_d   = path_q;
    lfsr_d   = lfsr_q;
    x_d      = x_q;
    y_d      = y_q;
    x_last_d = x_last_q;
    y_last_d = y_last_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          x_last_d = last_of(maze_width);
          y_last_d = last_of(maze_height);
          lfsr_d   = (seed == 16'h0) ? SEED_DFLT : seed;
          y_d      = 7'd0;
          state_d  = CLEAR;
        end
      end
      CLEAR: begin
        path_d[{y_q[5:0], 6'd0} +: GRID] = '0;
        if (y_q == 7'd63) begin
          x_d     = 7'd1;
          y_d     = 7'd1;
          state_d = CARVE;
        end else begin
          y_d = y_q + 7'd1;
        end
      end
      CARVE: begin
        path_d[cur_idx] = 1'b1;
        if (can_e && (!can_n || lfsr_q[0])) begin
          path_d[east_idx] = 1'b1;
        end else if (can_n) begin
          path_d[north_idx] = 1'b1;
        end
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0);
        if (x_q == x_last_q && y_q == y_last_q) begin
          state_d = FINISH;
        end else if (x_q + 7'd2 > x_last_q) begin
          x_d = 7'd1;
          y_d = y_q + 7'd2;
        end else begin
          x_d = x_q + 7'd2;
        end
      end
      FINISH: begin
        path_d[12'd64]   = 1'b1;
        path_d[exit_idx] = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      path_q   <= '0;
      lfsr_q   <= SEED_DFLT;
      x_q      <= 7'd0;
      y_q      <= 7'd0;
      x_last_q <= 7'd1;
      y_last_q <= 7'd1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      path_q   <= path_d;
      lfsr_q   <= lfsr_d;
      x_q      <= x_d;
      y_q      <= y_d;
      x_last_q <= x_last_d;
      y_last_q <= y_last_d;
      done_q   <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign path_data = path_q;

endmodule

// File: tb/tb_maze_path_generator.sv
// Self-checking bench for maze_path_generator against a cell-level
// binary-tree maze model, with latency and connectivity checks.
module tb_maze_path_generator;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [15:0]   seed;
  logic [6:0]    maze_width;
  logic [6:0]    maze_height;
  logic          busy;
  logic          done;
  logic [4095:0] path_data;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t0       = 0;

  logic [4095:0] exp_map;
  int            exp_lat;
  int            exp_ex;
  int            exp_ey;

  maze_path_generator dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .seed        (seed),
    .maze_width  (maze_width),
    .maze_height (maze_height),
    .busy        (busy),
    .done        (done),
    .path_data   (path_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: walk the cell grid row by row with its own LFSR.
  task automatic model(input int w, input int h, input logic [15:0] sd);
    int cw, ch, cols, rows, x, y;
    logic [15:0] lf;
    cw = (w < 3) ? 3 : ((w > 64) ? 64 : w);
    ch = (h < 3) ? 3 : ((h > 64) ? 64 : h);
    cols = (cw - 1) / 2;
    rows = (ch - 1) / 2;
    lf = (sd == 16'h0) ? 16'hACE1 : sd;
    exp_map = '0;
    for (int cy = 0; cy < rows; cy++) begin
      for (int cx = 0; cx < cols; cx++) begin
        x = 2 * cx + 1;
        y = 2 * cy + 1;
        exp_map[x + 64 * y] = 1'b1;
        if (cx < cols - 1 && (cy == 0 || lf[0]))
          exp_map[x + 1 + 64 * y] = 1'b1;
        else if (cy > 0)
          exp_map[x + 64 * (y - 1)] = 1'b1;
        lf = {1'b0, lf[15:1]} ^ (lf[0] ? 16'hB400 : 16'h0);
      end
    end
    exp_ex = 2 * cols;
    exp_ey = 2 * rows - 1;
    exp_map[64] = 1'b1;
    exp_map[exp_ex + 64 * exp_ey] = 1'b1;
    exp_lat = 65 + cols * rows;
  endtask

  task automatic flood(input logic [4095:0] m, input int ex, input int ey,
                       output int nvis, output bit hit);
    logic [4095:0] vis;
    int q[$];
    int p, x, y, nx, ny;
    vis = '0;
    nvis = 0;
    hit = 1'b0;
    if (m[64]) begin
      q.push_back(64);
      vis[64] = 1'b1;
    end
    while (q.size() > 0) begin
      p = q.pop_front();
      nvis++;
      x = p % 64;
      y = p / 64;
      if (x == ex && y == ey) hit = 1'b1;
      for (int d = 0; d < 4; d++) begin
        nx = x + ((d == 0) ? 1 : ((d == 1) ? -1 : 0));
        ny = y + ((d == 2) ? 1 : ((d == 3) ? -1 : 0));
        if (nx >= 0 && nx < 64 && ny >= 0 && ny < 64) begin
          if (m[nx + 64 * ny] && !vis[nx + 64 * ny]) begin
            vis[nx + 64 * ny] = 1'b1;
            q.push_back(nx + 64 * ny);
          end
        end
      end
    end
  endtask

  task automatic start_gen(input logic [6:0] w, input logic [6:0] h,
                           input logic [15:0] sd);
    @(negedge clk);
    maze_width  = w;
    maze_height = h;
    seed        = sd;
    start       = 1'b1;
    @(posedge clk);
    #1;
    t0    = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = cyc - t0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    seed = 16'h0;
    maze_width = 7'd0;
    maze_height = 7'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (path_data !== '0) begin
      failures++;
      $display("FAIL reset_path pop=%0d exp=0", $countones(path_data));
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL reset_done got=%b exp=0", done);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_min;
    logic [4095:0] e;
    int lat;
    e = '0;
    e[64] = 1'b1;
    e[65] = 1'b1;
    e[66] = 1'b1;
    start_gen(7'd3, 7'd3, 16'h1);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL min_busy got=%b exp=1", busy);
    end
    wait_done(lat);
    checks++;
    if (lat !== 66) begin
      failures++;
      $display("FAIL min_lat got=%0d exp=66", lat);
    end
    checks++;
    if (path_data !== e) begin
      failures++;
      $display("FAIL min_map pop=%0d exp_pop=3", $countones(path_data));
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL min_busy_at_done got=%b exp=0", busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL min_done_pulse got=%b exp=0", done);
    end
  endtask

  task automatic test_wide;
    logic [4095:0] e;
    int lat;
    e = '0;
    for (int i = 64; i <= 68; i++) e[i] = 1'b1;
    start_gen(7'd5, 7'd3, 16'h5A5A);
    wait_done(lat);
    checks++;
    if (lat !== 67) begin
      failures++;
      $display("FAIL wide_lat got=%0d exp=67", lat);
    end
    checks++;
    if (path_data !== e) begin
      failures++;
      $display("FAIL wide_map pop=%0d exp_pop=5", $countones(path_data));
    end
  endtask

  task automatic test_tall;
    logic [4095:0] e;
    int lat;
    e = '0;
    for (int y = 1; y <= 5; y++) e[1 + 64 * y] = 1'b1;
    e[64] = 1'b1;
    e[2 + 64 * 5] = 1'b1;
    start_gen(7'd3, 7'd7, 16'h0F0F);
    wait_done(lat);
    checks++;
    if (lat !== 68) begin
      failures++;
      $display("FAIL tall_lat got=%0d exp=68", lat);
    end
    checks++;
    if (path_data !== e) begin
      failures++;
      $display("FAIL tall_map pop=%0d exp_pop=7", $countones(path_data));
    end
  endtask

  task automatic test_full;
    int lat, nvis;
    bit hit;
    model(64, 64, 16'h1234);
    start_gen(7'd64, 7'd64, 16'h1234);
    wait_done(lat);
    checks++;
    if (lat !== 1026) begin
      failures++;
      $display("FAIL full_lat got=%0d exp=1026", lat);
    end
    checks++;
    if ($countones(path_data) !== 1923) begin
      failures++;
      $display("FAIL full_pop got=%0d exp=1923", $countones(path_data));
    end
    checks++;
    if (path_data !== exp_map) begin
      failures++;
      $display("FAIL full_map pop=%0d exp_pop=%0d",
               $countones(path_data), $countones(exp_map));
    end
    flood(path_data, 62, 61, nvis, hit);
    checks++;
    if (nvis !== 1923 || hit !== 1'b1) begin
      failures++;
      $display("FAIL full_flood reached=%0d exit=%b exp=1923/1", nvis, hit);
    end
  endtask

  task automatic test_seed_zero;
    logic [4095:0] ref_map;
    int lat;
    start_gen(7'd64, 7'd64, 16'hACE1);
    wait_done(lat);
    ref_map = path_data;
    start_gen(7'd64, 7'd64, 16'h0);
    wait_done(lat);
    checks++;
    if (path_data !== ref_map || lat !== 1026) begin
      failures++;
      $display("FAIL seed_zero pop=%0d ref_pop=%0d lat=%0d exp=1026",
               $countones(path_data), $countones(ref_map), lat);
    end
  endtask

  task automatic test_random;
    int lat, w, h, nvis;
    logic [15:0] sd;
    bit hit;
    for (int k = 0; k < 10; k++) begin
      w = $urandom_range(0, 127);
      h = $urandom_range(0, 127);
      sd = (k == 3) ? 16'h0 : 16'($urandom);
      model(w, h, sd);
      start_gen(7'(w), 7'(h), sd);
      wait_done(lat);
      checks++;
      if (lat !== exp_lat) begin
        failures++;
        $display("FAIL rand_lat w=%0d h=%0d got=%0d exp=%0d", w, h, lat, exp_lat);
      end
      checks++;
      if (path_data !== exp_map) begin
        failures++;
        $display("FAIL rand_map w=%0d h=%0d seed=%h pop=%0d exp_pop=%0d",
                 w, h, sd, $countones(path_data), $countones(exp_map));
      end
      flood(path_data, exp_ex, exp_ey, nvis, hit);
      checks++;
      if (nvis !== $countones(exp_map) || hit !== 1'b1) begin
        failures++;
        $display("FAIL rand_flood w=%0d h=%0d reached=%0d exit=%b exp=%0d/1",
                 w, h, nvis, hit, $countones(exp_map));
      end
    end
  endtask

  task automatic test_start_ignored;
    int lat;
    model(9, 9, 16'hBEEF);
    start_gen(7'd9, 7'd9, 16'hBEEF);
    repeat (70) @(posedge clk);
    @(negedge clk);
    maze_width = 7'd64;
    maze_height = 7'd64;
    seed = 16'h1111;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    checks++;
    if (lat !== exp_lat) begin
      failures++;
      $display("FAIL ignore_lat got=%0d exp=%0d", lat, exp_lat);
    end
    checks++;
    if (path_data !== exp_map) begin
      failures++;
      $display("FAIL ignore_map pop=%0d exp_pop=%0d",
               $countones(path_data), $countones(exp_map));
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    logic [15:0] sd;
    start_gen(7'd64, 7'd64, 16'h4321);
    repeat (200) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (path_data !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid pop=%0d busy=%b done=%b exp=0/0/0",
               $countones(path_data), busy, done);
    end
    @(negedge clk);
    reset = 1'b0;
    sd = 16'($urandom);
    model(7, 5, sd);
    start_gen(7'd7, 7'd5, sd);
    wait_done(lat);
    checks++;
    if (lat !== 71) begin
      failures++;
      $display("FAIL after_reset_lat got=%0d exp=71", lat);
    end
    checks++;
    if (path_data !== exp_map) begin
      failures++;
      $display("FAIL after_reset_map pop=%0d exp_pop=%0d",
               $countones(path_data), $countones(exp_map));
    end
  endtask

  initial begin
    test_reset;
    test_min;
    test_wide;
    test_tall;
    test_full;
    test_seed_zero;
    test_random;
    test_start_ignored;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
